posit_norm_enc: RTL and testbench
=================================

// Module: posit_norm_enc
// PURPOSE
//  Encodes the accumulator's fixed-point result (two's-complement accumulator plus block exponent) into posit<N,ES>.
//  The accumulator is the sender; this block closes the MAC datapath on the output side.
//  Multi-cycle: magnitude, 1-bit/cycle normalize, then regime/exponent/fraction packing with RNE rounding.
//  start/busy/done handshake.
// PARAMETERS
//  ACC_W     32  accumulator width (two's complement)
//  EXP_W     5   block exponent width (unsigned)
//  EXP_BIAS  15  exponent bias
//  FRAC_W    16  binary-point position inside accumulator
//  N         8   posit width
//  ES        1   posit exponent-field width
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      asynchronous, active-high reset
//  start           in   1      request; sampled only when busy=0
//  exp_in          in   EXP_W  block exponent of fixed_point_in
//  fixed_point_in  in   ACC_W  signed accumulator value
//  posit_out       out  N      encoded posit; held until next done
//  busy            out  1      conversion in progress
//  done            out  1      one-cycle pulse, posit_out valid
// BEHAVIOUR
//  Value = fixed_point_in * 2^(exp_in-EXP_BIAS-FRAC_W).
//  Reset (async, rst=1): state=IDLE, posit_out=0, busy=0, done=0. Also applies when rst is asserted mid-conversion; the partial result is discarded.
//  IDLE: start=1 at edge T0 -> latch inputs, sign=msb, busy<=1, go to ABS.
//  ABS (edge T1): mag=|acc| as an ACC_W-bit unsigned value (0x80..0 -> 2^(ACC_W-1)).
//    scale<=exp_in-EXP_BIAS+(ACC_W-1-FRAC_W), signed, >=EXP_W+2 bits.
//    If mag==0: posit_out<=0, done<=1, busy<=0, go to IDLE. Otherwise go to NORM.
//  NORM: each edge, if mag[ACC_W-1]==0, shift mag left 1 and scale-=1; else go to PACK.
//    Takes lz+1 edges, where lz = leading zeros of mag.
//  PACK (edge T0+3+lz): k=floor(scale/2^ES), e=scale mod 2^ES.
//    Regime: k>=0 -> (k+1) ones then 0; k<0 -> (-k) zeros then 1.
//    Then e, then fraction = mag bits below MSB.
//    Truncate to N-1 bits. Round to nearest even: guard = first dropped bit, sticky = OR of the rest.
//    A rounding carry may ripple into e/regime.
//    Saturate: scale>(N-2)*2^ES or rounded overflow -> maxpos (0..01..1).
//    A nonzero value never rounds to 0 -> minpos (0..01).
//    If sign set, posit_out = two's complement of the magnitude encoding.
//    NaR is never produced.
//    posit_out registered, done<=1 for one cycle, busy<=0, go to IDLE.
//  Latency: nonzero = done high after edge T0+3+lz; zero = after edge T1.
//  start while busy=1: ignored, inputs not re-latched.
//  start may be asserted in the cycle done=1 (busy=0 there): accepted back-to-back.
//  Inputs need only be stable at the accepting edge.
//  busy=1 from edge T0 until the edge that raises done.
// TESTING
//  acc=0x00010000, exp=15 (1.0) -> posit_out=0x40; done 1 cycle after edge T0+18 (lz=15); busy high until then.
//  acc=0xFFFF0000, exp=15 (-1.0) -> 0xC0. acc=0x00018000, exp=15 (1.5) -> 0x48.
//  Rounding: acc=0x00010800 (tie, even) -> 0x40; acc=0x00011800 (tie, odd lsb) -> 0x42.
//  Zero and extremes:
//    acc=0, exp=7 -> 0x00, done after edge T1.
//    acc=0x7FFFFFFF, exp=31 -> 0x7F.
//    acc=0x80000000, exp=31 -> 0x81.
//    acc=0x00000001, exp=0 -> 0x01.
//  Protocol:
//    Pulse start again mid-NORM -> ignored; only the first result is produced.
//    Then assert rst mid-NORM -> busy=0, done=0, posit_out=0x00.
//    A new start after reset converts correctly.
//  Back-to-back: start held high across 3 conversions (1.0, -1.0, 0) -> done pulses in order with 0x40, 0xC0, 0x00.

Source files
------------

// File: rtl/posit_norm_enc.sv
// Converts a two's-complement accumulator with a block exponent into a posit<N,ES>.
// The datapath runs over several cycles: magnitude, 1-bit/cycle normalize, then pack with round-to-nearest-even.
module posit_norm_enc #(
    parameter int ACC_W    = 32,
    parameter int EXP_W    = 5,
    parameter int EXP_BIAS = 15,
    parameter int FRAC_W   = 16,
    parameter int N        = 8,
    parameter int ES       = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [EXP_W-1:0]   exp_in,
    input  logic [ACC_W-1:0]   fixed_point_in,
    output logic [N-1:0]       posit_out,
    output logic               busy,
    output logic               done
);

    localparam int SW     = EXP_W + $clog2(ACC_W) + 2;
    localparam int TAIL_W = ES + ACC_W - 1;
    localparam int PAD_W  = N + 2;
    localparam int XW     = 2 + TAIL_W + PAD_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ABS  = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_PACK = 2'd3;

    localparam logic signed [SW-1:0] C_BIAS    = SW'(EXP_BIAS);
    localparam logic signed [SW-1:0] C_OFFSET  = SW'(ACC_W - 1 - FRAC_W);
    localparam logic signed [SW-1:0] C_SATSCL  = SW'((N - 2) << ES);
    localparam logic signed [SW-1:0] C_MAXPOS  = SW'(N);
    localparam logic signed [SW-1:0] C_MAXNEG  = SW'(N + 1);

    logic [1:0]              r_state;
    logic [ACC_W-1:0]        r_acc;
    logic [EXP_W-1:0]        r_exp;
    logic                    r_sign;
    logic [ACC_W-1:0]        r_mag;
    logic signed [SW-1:0]    r_scale;
    logic [N-1:0]            r_posit;
    logic                    r_busy;
    logic                    r_done;

    logic [ACC_W-1:0]        w_absMag;
    logic signed [SW-1:0]    w_initScale;
    logic signed [SW-1:0]    w_k;
    logic signed [SW-1:0]    w_negK;
    logic [ES-1:0]           w_e;
    logic [TAIL_W-1:0]       w_tail;
    logic [XW-1:0]           w_xPos;
    logic [XW-1:0]           w_xNeg;
    logic [SW-1:0]           w_shift;
    logic [XW-1:0]           w_shifted;
    logic [N-2:0]            w_trunc;
    logic                    w_guard;
    logic                    w_sticky;
    logic                    w_roundUp;
    logic [N-1:0]            w_rounded;
    logic                    w_sat;
    logic [N-2:0]            w_magEnc;
    logic [N-1:0]            w_posit;

    // Most negative accumulator wraps to itself, which reads correctly as 2^(ACC_W-1) unsigned.
    assign w_absMag    = r_acc[ACC_W-1] ? (~r_acc + ACC_W'(1)) : r_acc;
    assign w_initScale = $signed({{(SW-EXP_W){1'b0}}, r_exp}) - C_BIAS + C_OFFSET;

    assign w_k    = r_scale >>> ES;
    assign w_negK = -w_k - SW'(1);
    assign w_e    = r_scale[ES-1:0];
    assign w_tail = {w_e, r_mag[ACC_W-2:0]};
    assign w_xPos = {2'b10, w_tail, {PAD_W{1'b0}}};
    assign w_xNeg = {2'b01, w_tail, {PAD_W{1'b0}}};

    // Shift clamps never change the outcome: large regimes saturate, tiny ones become minpos.
    always_comb begin
        w_shift = '0;
        if (!w_k[SW-1]) begin
            w_shift = (w_k > C_MAXPOS) ? C_MAXPOS : w_k;
        end else begin
            w_shift = (w_negK > C_MAXNEG) ? C_MAXNEG : w_negK;
        end
    end

    assign w_shifted = w_k[SW-1] ? (w_xNeg >> w_shift)
                                 : ((w_xPos >> w_shift) | ~({XW{1'b1}} >> w_shift));

    assign w_trunc   = w_shifted[XW-1 -: N-1];
    assign w_guard   = w_shifted[XW-N];
    assign w_sticky  = |w_shifted[XW-N-1:0];
    assign w_roundUp = w_guard & (w_sticky | w_trunc[0]);
    assign w_rounded = {1'b0, w_trunc} + N'(w_roundUp);
    assign w_sat     = (r_scale > C_SATSCL) | w_rounded[N-1];

    always_comb begin
        w_magEnc = w_rounded[N-2:0];
        if (w_sat) begin
            w_magEnc = {(N-1){1'b1}};
        end else if (w_rounded[N-2:0] == '0) begin
            w_magEnc = (N-1)'(1);
        end
    end

    assign w_posit = r_sign ? (~{1'b0, w_magEnc} + N'(1)) : {1'b0, w_magEnc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_exp   <= '0;
            r_sign  <= 1'b0;
            r_mag   <= '0;
            r_scale <= '0;
            r_posit <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc   <= fixed_point_in;
                        r_exp   <= exp_in;
                        r_sign  <= fixed_point_in[ACC_W-1];
                        r_busy  <= 1'b1;
                        r_state <= S_ABS;
                    end
                end
                S_ABS: begin
                    r_mag   <= w_absMag;
                    r_scale <= w_initScale;
                    if (w_absMag == '0) begin
                        r_posit <= '0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (!r_mag[ACC_W-1]) begin
                        r_mag   <= r_mag << 1;
                        r_scale <= r_scale - SW'(1);
                    end else begin
                        r_state <= S_PACK;
                    end
                end
                S_PACK: begin
                    r_posit <= w_posit;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign posit_out = r_posit;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_posit_norm_enc.sv
// Directed bench for posit_norm_enc: expected posits and latencies are queued when a
// conversion is launched and matched against each done pulse.
module tb_posit_norm_enc;

    localparam int ACC_W   = 32;
    localparam int EXP_W   = 5;
    localparam int N       = 8;
    localparam int TIMEOUT = 100;

    logic               clk;
    logic               rst;
    logic               start;
    logic [EXP_W-1:0]   exp_in;
    logic [ACC_W-1:0]   fixed_point_in;
    logic [N-1:0]       posit_out;
    logic               busy;
    logic               done;

    typedef struct {
        logic [N-1:0] posit;
        int           acceptCycle;
        int           latency;
        string        tag;
    } ExpEntry;

    ExpEntry scoreboard[$];
    int vectorCount = 0;
    int missCount   = 0;
    int cycle       = 0;
    int a1;
    int a2;
    int a3;

    posit_norm_enc dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .exp_in         (exp_in),
        .fixed_point_in (fixed_point_in),
        .posit_out      (posit_out),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectorCount++;
        assert (got === want) else begin
            missCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Leading zeros of |acc| determine how many normalize steps the conversion needs.
    function automatic int latencyFor(input logic [ACC_W-1:0] acc);
        logic [ACC_W-1:0] m;
        int lz;
        m = acc[ACC_W-1] ? (~acc + 32'd1) : acc;
        if (m == '0) return 1;
        lz = 0;
        for (int i = ACC_W - 1; i >= 0; i--) begin
            if (m[i]) break;
            lz++;
        end
        return 3 + lz;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            checkOutput("done_expected", 32'(scoreboard.size() != 0), 32'd1);
            if (scoreboard.size() != 0) begin
                ExpEntry e;
                e = scoreboard.pop_front();
                checkOutput({e.tag, "_posit"}, 32'(posit_out), 32'(e.posit));
                checkOutput({e.tag, "_latency"}, 32'(cycle - e.acceptCycle), 32'(e.latency));
            end
        end
    end

    task automatic applyStimulus(input logic [ACC_W-1:0] acc, input logic [EXP_W-1:0] ex,
                                 input logic [N-1:0] want, input string tag);
        ExpEntry e;
        fixed_point_in = acc;
        exp_in         = ex;
        start          = 1'b1;
        e = '{want, cycle + 1, latencyFor(acc), tag};
        scoreboard.push_back(e);
        @(negedge clk);
        start          = 1'b0;
        fixed_point_in = $urandom;
        exp_in         = EXP_W'($urandom);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic waitDrain(input logic [N-1:0] want, input string tag);
        int i;
        i = 0;
        while (scoreboard.size() != 0 && i < TIMEOUT) begin
            @(posedge clk);
            i++;
        end
        checkOutput({tag, "_timeout"}, 32'(scoreboard.size()), 32'd0);
        scoreboard.delete();
        @(negedge clk);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
        checkOutput({tag, "_hold"}, 32'(posit_out), 32'(want));
    endtask

    task automatic runCase(input logic [ACC_W-1:0] acc, input logic [EXP_W-1:0] ex,
                           input logic [N-1:0] want, input string tag);
        applyStimulus(acc, ex, want, tag);
        waitDrain(want, tag);
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        exp_in         = '0;
        fixed_point_in = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_posit", 32'(posit_out), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        runCase(32'h0001_0000, 5'd15, 8'h40, "one");
        runCase(32'hFFFF_0000, 5'd15, 8'hC0, "minus_one");
        runCase(32'h0001_8000, 5'd15, 8'h48, "one_half_up");
        runCase(32'hFFFE_8000, 5'd15, 8'hB8, "minus_1p5");
        runCase(32'h0001_0800, 5'd15, 8'h40, "tie_even");
        runCase(32'h0001_1800, 5'd15, 8'h42, "tie_odd");
        runCase(32'h0001_0000, 5'd16, 8'h50, "two");
        runCase(32'h0000_8000, 5'd15, 8'h30, "half");
        runCase(32'h0000_4000, 5'd15, 8'h20, "quarter");
        runCase(32'h0000_0000, 5'd7,  8'h00, "zero");
        runCase(32'h7FFF_FFFF, 5'd31, 8'h7F, "max_pos_acc");
        runCase(32'h8000_0000, 5'd31, 8'h81, "max_neg_acc");
        runCase(32'h0000_0001, 5'd0,  8'h01, "tiny");
        runCase(32'h0001_0000, 5'd27, 8'h7F, "maxpos_exact");
        runCase(32'h0001_0000, 5'd28, 8'h7F, "sat_scale");
        runCase(32'h0001_0000, 5'd3,  8'h01, "minpos_exact");
        runCase(32'h0001_0000, 5'd1,  8'h01, "below_minpos");

        // A second start during normalize must not disturb the first conversion.
        applyStimulus(32'h0001_0000, 5'd15, 8'h40, "ignore_start");
        repeat (4) @(negedge clk);
        start          = 1'b1;
        fixed_point_in = 32'hFFFF_0000;
        exp_in         = 5'd15;
        @(negedge clk);
        start = 1'b0;
        waitDrain(8'h40, "ignore_start");
        repeat (25) @(negedge clk);

        applyStimulus(32'h0001_0000, 5'd15, 8'h40, "reset_mid");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("reset_mid_busy", 32'(busy), 32'd0);
        checkOutput("reset_mid_done", 32'(done), 32'd0);
        checkOutput("reset_mid_posit", 32'(posit_out), 32'd0);
        scoreboard.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        runCase(32'h0001_8000, 5'd15, 8'h48, "after_reset");

        // start held high: each conversion is accepted the edge after the previous done.
        fixed_point_in = 32'h0001_0000;
        exp_in         = 5'd15;
        start          = 1'b1;
        a1 = cycle + 1;
        scoreboard.push_back('{8'h40, a1, 18, "b2b_one"});
        @(negedge clk);
        fixed_point_in = 32'hFFFF_0000;
        a2 = a1 + 19;
        scoreboard.push_back('{8'hC0, a2, 18, "b2b_minus_one"});
        while (cycle < a2) @(negedge clk);
        fixed_point_in = 32'h0000_0000;
        exp_in         = 5'd7;
        a3 = a2 + 19;
        scoreboard.push_back('{8'h00, a3, 1, "b2b_zero"});
        while (cycle < a3) @(negedge clk);
        start = 1'b0;
        waitDrain(8'h00, "b2b");

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
